key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEB_CNT, default 1_000_000, stable-sample cycles required to accept a level change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter LONG_CNT, default 50_000_000, held-press cycles before long-press event; legal range 2..2^26-1.
REQ-003 sys_clk  input  1  single clock, all logic on rising edge.
REQ-004 sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 key_in  input  1  raw mechanical key, active-low, asynchronous, bouncing.
REQ-006 key_value  output  1  debounced key level, 1 = released.
REQ-007 key_press  output  1  one-cycle pulse on accepted press.
REQ-008 key_release  output  1  one-cycle pulse on accepted release.
REQ-009 key_long  output  1  one-cycle pulse on long press (see Configuration).
REQ-010 led  output  1  toggles on every accepted press.

Function
REQ-011 key_in SHALL pass through a 2-flop synchronizer (s1, s2); all decisions SHALL use s2 only.
REQ-012 FSM SHALL have states IDLE, PRESS_FILT, PRESSED, REL_FILT; one-hot or binary encoding is free.
REQ-013 IDLE: s2=0 -> PRESS_FILT, cnt cleared to 0.
REQ-014 PRESS_FILT: s2=1 -> IDLE, cnt cleared (bounce rejected); else cnt+1; at cnt=DEB_CNT-1 with s2=0 -> PRESSED, key_value<=0, key_press=1 for one cycle, led inverted.
REQ-015 Press latency SHALL be exactly DEB_CNT+3 rising edges, counting the first edge sampling key_in=0 as edge 1; key_press visible in the cycle after edge DEB_CNT+3.
REQ-016 PRESSED: s2=1 -> REL_FILT, cnt cleared; REL_FILT mirrors PRESS_FILT: s2=0 -> PRESSED (bounce rejected, no events); cnt=DEB_CNT-1 with s2=1 -> IDLE, key_value<=1, key_release=1 for one cycle.
REQ-017 Any bounce shorter than DEB_CNT cycles SHALL produce no pulse and no key_value change.
REQ-018 cnt width SHALL be ceil(log2(max(DEB_CNT,LONG_CNT)+1)); cnt SHALL saturate, never wrap.
REQ-019 key_press, key_release, key_long SHALL never be asserted in the same cycle, nor two consecutive cycles.

Reset
REQ-020 sys_rst_n=0 SHALL immediately force state IDLE, cnt=0, s1=s2=1, key_value=1, key_press=key_release=key_long=0, led=0.
REQ-021 Reset mid-filter or mid-press SHALL discard progress; after release of reset with key_in held 0, a full DEB_CNT+3 press sequence SHALL be required.

Configuration
REQ-022 Macro KEY_LONG_PRESS_EN: when defined, PRESSED SHALL run a held counter; at LONG_CNT cycles in PRESSED (counted from the key_press cycle) key_long SHALL pulse once per press; REL_FILT bounce back to PRESSED SHALL not restart or re-arm it.
REQ-023 Without KEY_LONG_PRESS_EN, key_long SHALL be tied 0 and no held-counter logic SHALL be synthesized; all other behaviour identical.

Verification (DEB_CNT=4, LONG_CNT=16, 10 ns clock)
REQ-024 Reset with key_in=1 -> key_value=1, led=0, all pulses 0.
REQ-025 key_in low 3 cycles, high 2, low 2, high -> no key_press, key_value stays 1, led stays 0.
REQ-026 key_in low held 20 cycles -> key_press one cycle after edge 7, led=1, key_value=0; with KEY_LONG_PRESS_EN key_long one pulse 16 cycles after key_press, without it key_long=0.
REQ-027 From PRESSED, key_in high 2 cycles, low 2, then high held -> single key_release DEB_CNT+3 edges after final rising key_in, key_value=1.
REQ-028 Two clean presses -> led 0->1->0, exactly two key_press pulses.
REQ-029 Assert sys_rst_n=0 during PRESS_FILT (cnt=2) and during PRESSED -> outputs return to REQ-020 values asynchronously, no pulse emitted.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: debounces an active-low mechanical key.
// Outputs:
//   - key_value: debounced key level
//   - key_press / key_release: one-cycle pulses on each accepted change
//   - led: toggles on every accepted press
// Optional feature macro: KEY_LONG_PRESS_EN.
//   - When defined, a held counter in PRESSED emits one key_long pulse per press.
//   - When undefined, key_long is tied low and the held counter is not built.
module key_debounce #(
  parameter int DEB_CNT  = 1_000_000,
  parameter int LONG_CNT = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_value,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic led
);

  localparam int MAXC = (DEB_CNT > LONG_CNT) ? DEB_CNT : LONG_CNT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    PRESSED    = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          s1, s2;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          kv_nxt, press_nxt, rel_nxt, led_nxt;

  // Saturating increment: a stuck count can never wrap back into range.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  // Two-flop synchronizer; idles high (released) out of reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_in;
      s2 <= s1;
    end
  end

  // State, filter count and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_value   <= 1'b1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      led         <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_value   <= kv_nxt;
      key_press   <= press_nxt;
      key_release <= rel_nxt;
      led         <= led_nxt;
    end
  end

  // Next-state and output decode. A level change is accepted only after
  // DEB_CNT consecutive samples of the new level in the filter state;
  // any sample of the old level bounces back and discards the count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kv_nxt    = key_value;
    press_nxt = 1'b0;
    rel_nxt   = 1'b0;
    led_nxt   = led;
    case (state)
      IDLE: begin
        if (!s2) begin
          state_nxt = PRESS_FILT;
          cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (s2) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          kv_nxt    = 1'b0;
          press_nxt = 1'b1;
          led_nxt   = ~led;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      PRESSED: begin
        if (s2) begin
          state_nxt = REL_FILT;
          cnt_nxt   = '0;
        end
      end
      REL_FILT: begin
        if (!s2) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          kv_nxt    = 1'b1;
          rel_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);

  logic [CW-1:0] hcnt;
  logic          long_done;

  // Held counter.
  //   - Armed by the accepted press.
  //   - Advances only while in PRESSED.
  //   - Not reset by a release bounce, so one pulse fires per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hcnt      <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (press_nxt) begin
        hcnt      <= '0;
        long_done <= 1'b0;
      end else if (state == PRESSED && !long_done) begin
        if (hcnt == LONG_LAST) begin
          key_long  <= 1'b1;
          long_done <= 1'b1;
        end else begin
          hcnt <= (hcnt == {CW{1'b1}}) ? hcnt : hcnt + CW'(1);
        end
      end
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEB_CNT=4, LONG_CNT=16, 10 ns clock).
module tb_key_debounce;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic key_in;
  logic key_value, key_press, key_release, key_long, led;

  int checks = 0;
  int errors = 0;
  int cyc, np, nr, nl, fp, fr, fl;
  int tot_press = 0;

  key_debounce #(.DEB_CNT(4), .LONG_CNT(16)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_value   (key_value),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .led         (led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    cyc = 0; np = 0; nr = 0; nl = 0; fp = -1; fr = -1; fl = -1;
  endtask

  // Advance n edges, sampling 1 ns after each rising edge and logging pulses.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      cyc++;
      if (key_press)   begin np++; tot_press++; if (fp < 0) fp = cyc; end
      if (key_release) begin nr++; if (fr < 0) fr = cyc; end
      if (key_long)    begin nl++; if (fl < 0) fl = cyc; end
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 1'b1;
    clr();
    #23;
    chk("rst_value", key_value, 1);
    chk("rst_led", led, 0);
    chk("rst_pulses", {key_press, key_release, key_long}, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    run(3);

    // Short bounces: low 3, high 2, low 2, then high.
    clr();
    key_in = 1'b0; run(3);
    key_in = 1'b1; run(2);
    key_in = 1'b0; run(2);
    key_in = 1'b1; run(12);
    chk("bounce_press", np, 0);
    chk("bounce_value", key_value, 1);
    chk("bounce_led", led, 0);

    // Clean held press: pulse after edge 7, long pulse after edge 23.
    clr();
    key_in = 1'b0; run(30);
    chk("press_cnt", np, 1);
    chk("press_edge", fp, 7);
    chk("press_led", led, 1);
    chk("press_value", key_value, 0);
    chk("press_norel", nr, 0);
`ifdef KEY_LONG_PRESS_EN
    chk("long_cnt", nl, 1);
    chk("long_edge", fl, 23);
`else
    chk("long_cnt", nl, 0);
`endif

    // Release with bounce: high 2, low 2, then high (final rise before edge 5).
    clr();
    key_in = 1'b1; run(2);
    key_in = 1'b0; run(2);
    key_in = 1'b1; run(15);
    chk("rel_cnt", nr, 1);
    chk("rel_edge", fr, 11);
    chk("rel_value", key_value, 1);
    chk("rel_nopress", np, 0);
    chk("rel_led", led, 1);

    // Second clean press toggles led back to 0.
    clr();
    key_in = 1'b0; run(10);
    chk("press2_cnt", np, 1);
    chk("press2_led", led, 0);
    key_in = 1'b1; run(10);
    chk("rel2_cnt", nr, 1);
    chk("total_press", tot_press, 2);

    // Reset during PRESS_FILT with cnt=2, key kept low across reset.
    clr();
    key_in = 1'b0; run(5);
    chk("filt_cnt_pre", dut.cnt, 2);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstf_cnt", dut.cnt, 0);
    chk("rstf_value", key_value, 1);
    chk("rstf_pulses", {key_press, key_release, key_long}, 0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    clr();
    run(10);
    chk("rstf_repress_edge", fp, 7);
    chk("rstf_led", led, 1);

    // Reset while PRESSED.
    chk("pressed_value", key_value, 0);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rstp_value", key_value, 1);
    chk("rstp_led", led, 0);
    chk("rstp_pulses", {key_press, key_release, key_long}, 0);
    key_in = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    clr();
    run(10);
    chk("rstp_quiet", np + nr + nl, 0);
    chk("rstp_value2", key_value, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
